// File: rtl/sd_spi_card_model.sv
// Behavioural SD card responder in SPI mode. Oversamples sd_sck on clk and
// implements the CMD0/8/55/ACMD41/58/16/17 subset needed to boot and read blocks.
module sd_spi_card_model #(
    parameter int unsigned NCR_BYTES = 1,
    parameter logic [7:0]  READ_SEED = 8'h00,
    parameter int unsigned BLOCK_LEN = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sd_sck,
    input  logic       sd_mosi,
    input  logic       sd_cs,
    output logic       sd_miso,
    output logic       cmd_strobe,
    output logic [5:0] cmd_index,
    output logic       card_ready
);

    localparam int unsigned BLK_W  = 10;
    localparam int unsigned NCR_W  = 4;
    localparam int unsigned RESP_W = 40;

    typedef enum logic [2:0] {
        HUNT, CMD_RX, NCR, RESP, DATA_WAIT, DATA_TOK, DATA, CRC
    } state_t;

    logic [1:0]        sck_sync, mosi_sync, cs_sync;
    logic              sck_q;
    logic              cs_s_c, rise_c, fall_c, byte_done_c;
    logic [7:0]        rx_byte_c, r1_c;
    logic [BLK_W-1:0]  blk_inc_c;

    state_t            state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [6:0]        rx_shift, rx_shift_nxt;
    logic [7:0]        tx_shift, tx_shift_nxt;
    logic [2:0]        byte_cnt, byte_cnt_nxt;
    logic [5:0]        cmd_code, cmd_code_nxt;
    logic [7:0]        arg_lo, arg_lo_nxt;
    logic [NCR_W-1:0]  ncr_cnt, ncr_cnt_nxt;
    logic [RESP_W-1:0] resp_buf, resp_buf_nxt;
    logic [2:0]        resp_left, resp_left_nxt;
    logic              data_go, data_go_nxt;
    logic [7:0]        data_base, data_base_nxt;
    logic [BLK_W-1:0]  blk_cnt, blk_cnt_nxt;
    logic              crc_cnt, crc_cnt_nxt;
    logic              idle_flag, idle_flag_nxt;
    logic              app_flag, app_flag_nxt;
    logic [1:0]        acmd41_cnt, acmd41_cnt_nxt;
    logic              card_ready_nxt, sd_miso_nxt, cmd_strobe_nxt;
    logic [5:0]        cmd_index_nxt;

    // Input synchronisers plus one extra sck stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b11;
            cs_sync   <= 2'b11;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sd_sck};
            mosi_sync <= {mosi_sync[0], sd_mosi};
            cs_sync   <= {cs_sync[0], sd_cs};
            sck_q     <= sck_sync[1];
        end
    end

    assign cs_s_c      = cs_sync[1];
    assign rise_c      = sck_sync[1] & ~sck_q;
    assign fall_c      = ~sck_sync[1] & sck_q;
    assign rx_byte_c   = {rx_shift, mosi_sync[1]};
    assign byte_done_c = rise_c && !cs_s_c && (bit_cnt == 3'd7);
    assign blk_inc_c   = blk_cnt + BLK_W'(1);

    // Next-state: every byte boundary selects the byte transmitted in the next slot
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        rx_shift_nxt   = rx_shift;
        tx_shift_nxt   = tx_shift;
        byte_cnt_nxt   = byte_cnt;
        cmd_code_nxt   = cmd_code;
        arg_lo_nxt     = arg_lo;
        ncr_cnt_nxt    = ncr_cnt;
        resp_buf_nxt   = resp_buf;
        resp_left_nxt  = resp_left;
        data_go_nxt    = data_go;
        data_base_nxt  = data_base;
        blk_cnt_nxt    = blk_cnt;
        crc_cnt_nxt    = crc_cnt;
        idle_flag_nxt  = idle_flag;
        app_flag_nxt   = app_flag;
        acmd41_cnt_nxt = acmd41_cnt;
        card_ready_nxt = card_ready;
        sd_miso_nxt    = sd_miso;
        cmd_strobe_nxt = 1'b0;
        cmd_index_nxt  = cmd_index;
        r1_c           = {7'd0, idle_flag};

        if (cs_s_c) begin
            state_nxt    = HUNT;
            bit_cnt_nxt  = 3'd0;
            tx_shift_nxt = 8'hFF;
            sd_miso_nxt  = 1'b1;
        end else begin
            if (fall_c) begin
                sd_miso_nxt  = tx_shift[7];
                tx_shift_nxt = {tx_shift[6:0], 1'b1};
            end
            if (rise_c) begin
                rx_shift_nxt = rx_byte_c[6:0];
                bit_cnt_nxt  = bit_cnt + 3'd1;
            end
            if (byte_done_c) begin
                tx_shift_nxt = 8'hFF;
                case (state)
                    HUNT: begin
                        if (rx_byte_c[7:6] == 2'b01) begin
                            state_nxt    = CMD_RX;
                            byte_cnt_nxt = 3'd1;
                            cmd_code_nxt = rx_byte_c[5:0];
                        end
                    end
                    CMD_RX: begin
                        if (byte_cnt != 3'd5) begin
                            // only the low argument byte is ever used; it arrives last
                            byte_cnt_nxt = byte_cnt + 3'd1;
                            arg_lo_nxt   = rx_byte_c;
                        end else begin
                            state_nxt      = NCR;
                            ncr_cnt_nxt    = NCR_W'(1);
                            cmd_strobe_nxt = 1'b1;
                            cmd_index_nxt  = cmd_code;
                            app_flag_nxt   = (cmd_code == 6'd55);
                            data_go_nxt    = 1'b0;
                            resp_left_nxt  = 3'd0;
                            case (cmd_code)
                                6'd0: begin
                                    idle_flag_nxt  = 1'b1;
                                    acmd41_cnt_nxt = 2'd0;
                                    resp_buf_nxt   = {8'h01, 32'hFFFF_FFFF};
                                end
                                6'd8: begin
                                    resp_buf_nxt  = {r1_c, 8'h00, 8'h00, 8'h01, arg_lo};
                                    resp_left_nxt = 3'd4;
                                end
                                6'd16, 6'd55: begin
                                    resp_buf_nxt = {r1_c, 32'hFFFF_FFFF};
                                end
                                6'd41: begin
                                    if (app_flag) begin
                                        if (acmd41_cnt != 2'd3) begin
                                            acmd41_cnt_nxt = acmd41_cnt + 2'd1;
                                        end
                                        if (acmd41_cnt == 2'd0) begin
                                            resp_buf_nxt = {8'h01, 32'hFFFF_FFFF};
                                        end else begin
                                            idle_flag_nxt  = 1'b0;
                                            card_ready_nxt = 1'b1;
                                            resp_buf_nxt   = {8'h00, 32'hFFFF_FFFF};
                                        end
                                    end else begin
                                        resp_buf_nxt = {r1_c | 8'h04, 32'hFFFF_FFFF};
                                    end
                                end
                                6'd58: begin
                                    resp_buf_nxt  = {r1_c, (card_ready ? 8'hC0 : 8'h00),
                                                     8'hFF, 8'h80, 8'h00};
                                    resp_left_nxt = 3'd4;
                                end
                                6'd17: begin
                                    if (card_ready) begin
                                        resp_buf_nxt  = {8'h00, 32'hFFFF_FFFF};
                                        data_go_nxt   = 1'b1;
                                        data_base_nxt = READ_SEED + arg_lo;
                                    end else begin
                                        resp_buf_nxt = {8'h05, 32'hFFFF_FFFF};
                                    end
                                end
                                default: begin
                                    resp_buf_nxt = {r1_c | 8'h04, 32'hFFFF_FFFF};
                                end
                            endcase
                        end
                    end
                    NCR: begin
                        if (ncr_cnt == NCR_W'(NCR_BYTES)) begin
                            state_nxt    = RESP;
                            tx_shift_nxt = resp_buf[RESP_W-1 -: 8];
                            resp_buf_nxt = {resp_buf[RESP_W-9:0], 8'hFF};
                        end else begin
                            ncr_cnt_nxt = ncr_cnt + NCR_W'(1);
                        end
                    end
                    RESP: begin
                        if (resp_left == 3'd0) begin
                            state_nxt = data_go ? DATA_WAIT : HUNT;
                        end else begin
                            tx_shift_nxt  = resp_buf[RESP_W-1 -: 8];
                            resp_buf_nxt  = {resp_buf[RESP_W-9:0], 8'hFF};
                            resp_left_nxt = resp_left - 3'd1;
                        end
                    end
                    DATA_WAIT: begin
                        state_nxt    = DATA_TOK;
                        tx_shift_nxt = 8'hFE;
                    end
                    DATA_TOK: begin
                        state_nxt    = DATA;
                        blk_cnt_nxt  = BLK_W'(0);
                        tx_shift_nxt = data_base;
                    end
                    DATA: begin
                        if (blk_cnt == BLK_W'(BLOCK_LEN - 1)) begin
                            state_nxt    = CRC;
                            crc_cnt_nxt  = 1'b0;
                            tx_shift_nxt = 8'h00;
                        end else begin
                            blk_cnt_nxt  = blk_inc_c;
                            tx_shift_nxt = data_base + blk_inc_c[7:0];
                        end
                    end
                    CRC: begin
                        if (!crc_cnt) begin
                            crc_cnt_nxt  = 1'b1;
                            tx_shift_nxt = 8'h00;
                        end else begin
                            state_nxt   = HUNT;
                            data_go_nxt = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            tx_shift   <= 8'hFF;
            byte_cnt   <= 3'd0;
            cmd_code   <= 6'd0;
            arg_lo     <= 8'd0;
            ncr_cnt    <= NCR_W'(0);
            resp_buf   <= '1;
            resp_left  <= 3'd0;
            data_go    <= 1'b0;
            data_base  <= 8'd0;
            blk_cnt    <= BLK_W'(0);
            crc_cnt    <= 1'b0;
            idle_flag  <= 1'b1;
            app_flag   <= 1'b0;
            acmd41_cnt <= 2'd0;
            card_ready <= 1'b0;
            sd_miso    <= 1'b1;
            cmd_strobe <= 1'b0;
            cmd_index  <= 6'd0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            rx_shift   <= rx_shift_nxt;
            tx_shift   <= tx_shift_nxt;
            byte_cnt   <= byte_cnt_nxt;
            cmd_code   <= cmd_code_nxt;
            arg_lo     <= arg_lo_nxt;
            ncr_cnt    <= ncr_cnt_nxt;
            resp_buf   <= resp_buf_nxt;
            resp_left  <= resp_left_nxt;
            data_go    <= data_go_nxt;
            data_base  <= data_base_nxt;
            blk_cnt    <= blk_cnt_nxt;
            crc_cnt    <= crc_cnt_nxt;
            idle_flag  <= idle_flag_nxt;
            app_flag   <= app_flag_nxt;
            acmd41_cnt <= acmd41_cnt_nxt;
            card_ready <= card_ready_nxt;
            sd_miso    <= sd_miso_nxt;
            cmd_strobe <= cmd_strobe_nxt;
            cmd_index  <= cmd_index_nxt;
        end
    end

endmodule

// File: doc/sd_spi_card_model.md
Name: sd_spi_card_model

Overview:
- Behavioural SD-card responder in SPI mode. Sits directly downstream of the SDIO/SPI bridge in the Verilator test harness.
- Consumes sd_sck, the CMD line (MOSI) and DAT3 (chip select). Drives DAT0 (MISO) back toward the bridge's synchroniser.
- Implements enough of the SD SPI protocol (CMD0/8/55/ACMD41/58/16/17) for the boot ROM to initialise the card and read blocks.
- Fully synchronous to clk: it oversamples the SPI clock and does not clock on sd_sck.

Parameters:
NCR_BYTES, 1, number of 0xFF filler bytes between the end of a command frame and the first response byte (legal range 1..8)
READ_SEED, 8'h00, base value of the generated read-data pattern
BLOCK_LEN, 512, bytes per CMD17 data block

Ports:
clk  input  1  system clock; sd_sck frequency must not exceed clk/8
reset  input  1  asynchronous, active-high reset
sd_sck  input  1  SPI clock from bridge, mode 0
sd_mosi  input  1  CMD line; MSB-first command bytes
sd_cs  input  1  DAT3 line, active-low chip select
sd_miso  output  1  DAT0 line; idles high
cmd_strobe  output  1  one-cycle pulse when a 48-bit command frame completes
cmd_index  output  6  index of the last completed command; held until the next frame completes
card_ready  output  1  high once ACMD41 has cleared the idle state

Behaviour:
Reset and input sampling:
- Reset asserts immediately (async). State and outputs on reset: sd_miso=1, cmd_strobe=0, cmd_index=0, card_ready=0, idle_flag=1, app_flag=0, acmd41_cnt=0, FSM=HUNT.
- sd_sck, sd_mosi and sd_cs each pass through a 2-flop synchroniser.
- A rise event or fall event is asserted on the clk cycle where the synchronised sck changes.

Bit and byte timing:
- On a rise event with cs low: sample mosi into rx_shift and increment bit_cnt[2:0].
- When bit_cnt wraps 7->0: a byte is complete, and the next tx byte is loaded into tx_shift.
- On a fall event with cs low: sd_miso <= tx_shift[7], then tx_shift shifts left.
- When cs is high: sd_miso=1, bit_cnt=0, FSM forced to HUNT. Card flags are retained.
- A cs rise mid-frame aborts the frame silently; no cmd_strobe is issued.

FSM states:
- HUNT: tx=0xFF. A received byte whose top two bits are 01 starts a frame: go to CMD_RX with byte_cnt=1. Every other byte is ignored.
- CMD_RX: collect 5 more bytes. On the 6th byte:
  - pulse cmd_strobe and latch cmd_index = byte0[5:0] and arg = bytes1..4;
  - ignore the CRC;
  - decode the response, then go to NCR.
- NCR: send NCR_BYTES × 0xFF, then go to RESP.
- RESP: send R1, then any trailing bytes. R1 bit0 = idle_flag.
- Response table (MOSI is ignored outside HUNT and CMD_RX):
  - CMD0: R1=0x01; set idle_flag; clear app_flag and acmd41_cnt.
  - CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: R1; set app_flag. app_flag is consumed (cleared) by the next command.
  - CMD41 with app_flag set: increment acmd41_cnt (saturating). The 1st call returns 0x01. The 2nd and later calls return 0x00, clear idle_flag and set card_ready.
  - CMD58: R3 = R1 + OCR, where OCR = 0xC0FF8000 if card_ready, else 0x00FF8000.
  - CMD16: R1.
  - CMD17 when not ready: R1 = 0x05 (illegal | idle); no data.
  - CMD17 when ready: R1 = 0x00, then go to DATA_WAIT.
  - Any other command, including CMD41 without app_flag: R1 = 0x04 | idle_flag.
  - After the last response byte, go to HUNT (or DATA_WAIT for a successful CMD17).
- DATA_WAIT: send one 0xFF, then DATA_TOK sends 0xFE, then DATA.
- DATA: byte k (0..BLOCK_LEN-1) = READ_SEED + arg[7:0] + k, modulo 256 (8-bit wrap). Uses a 10-bit counter.
- CRC: send 0x00, 0x00, then go to HUNT.

Boundary rules:
- The response is byte-aligned to the command frame. The first response bit appears after the fall event following the 8th rise of the NCR_BYTES-th filler byte.
- Reset while a data block is in progress aborts immediately; sd_miso returns to 1 within the same cycle.

Test Plan:
- Reset, cs=0, clock 10 × 0xFF, then CMD0 (40 00 00 00 00 95) and 8 × 0xFF -> 1 filler 0xFF, then R1=0x01; cmd_strobe pulses once; cmd_index=0.
- CMD8 with arg 0x000001AA -> 0x01, 0x00, 0x00, 0x01, 0xAA.
- CMD55+ACMD41 twice -> first R1=0x01, second R1=0x00; card_ready rises. Then CMD58 -> 0x00, C0, FF, 80, 00.
- CMD17 with arg 0x00000010 when ready, READ_SEED=0 -> R1 0x00, 0xFF, 0xFE, then 512 bytes 0x10, 0x11, …, wrapping past 0xFF, then 0x00 0x00.
- CMD17 before init -> R1=0x05, then MISO stays 0xFF (no token).
- cs raised after 3 command bytes, then a full CMD0 -> no strobe for the aborted frame; CMD0 answered with 0x01. Separately, async reset mid-block -> sd_miso=1 and card_ready=0 immediately.
